// File: rtl/vend_controller_if.sv
// Dispenser handshake between vend_controller and the downstream coinDispenser.
// The controller drives the change amount and the dispense strobe, and the
// dispenser answers with its busy status and a done pulse.
interface vend_controller_if;
  logic       disp;
  logic [9:0] change;
  logic       dispBusy;
  logic       dispDone;

  modport master (
    output disp,
    output change,
    input  dispBusy,
    input  dispDone
  );

  modport slave (
    input  disp,
    input  change,
    output dispBusy,
    output dispDone
  );
endinterface

// File: rtl/vend_controller.sv
// Credit-accumulation and purchase controller. Coins build credit, and a
// purchase or cancel computes change. The change is handed to the dispenser
// with a one-cycle disp strobe, and the controller then waits for the
// dispenser's done pulse before it accepts new activity.
module vend_controller #(
  parameter int unsigned PRICE0       = 75,
  parameter int unsigned PRICE1       = 100,
  parameter int unsigned PRICE2       = 125,
  parameter int unsigned PRICE3       = 150,
  parameter int unsigned MAX_CREDIT   = 1000,
  parameter int unsigned DONE_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coinQuarter,
  input  logic              coinDime,
  input  logic              coinNickel,
  input  logic              coinDollar,
  input  logic              buy,
  input  logic              cancel,
  input  logic [1:0]        sel,
  vend_controller_if.master dispenser,
  output logic [9:0]        credit,
  output logic              vend,
  output logic [1:0]        vendSel,
  output logic              coinReject,
  output logic              lowCredit,
  output logic              busy,
  output logic              fault
);

  localparam int unsigned CW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CHANGE, WAIT_DONE, FAULT} state_t;

  state_t          state, state_d;
  logic [5:0]      hist, now, rise;
  logic [3:0]      coin_e;
  logic            buy_e, cancel_e, coin_any, coin_multi;
  logic [6:0]      coin_val;
  logic [9:0]      price;
  logic [10:0]     sum;
  logic [CW-1:0]   cnt, cnt_d, cnt_inc;
  logic [9:0]      credit_d, change_d;
  logic            disp_d, vend_d, rej_d, low_d, busy_d, fault_d;
  logic [1:0]      vsel_d;
  logic            unused_disp_busy;

  // dispBusy is status-only; no decision in this block depends on it.
  assign unused_disp_busy = dispenser.dispBusy;

  assign now      = {cancel, buy, coinDollar, coinNickel, coinDime, coinQuarter};
  assign rise     = now & ~hist;
  assign coin_e   = rise[3:0];
  assign buy_e    = rise[4];
  assign cancel_e = rise[5];

  // Decode the coin edges, the selected price and the widened credit sum.
  always_comb begin
    coin_val = '0;
    case (coin_e)
      4'b0001: coin_val = 7'd25;
      4'b0010: coin_val = 7'd10;
      4'b0100: coin_val = 7'd5;
      4'b1000: coin_val = 7'd100;
      default: coin_val = '0;
    endcase
    case (sel)
      2'd0:    price = 10'(PRICE0);
      2'd1:    price = 10'(PRICE1);
      2'd2:    price = 10'(PRICE2);
      default: price = 10'(PRICE3);
    endcase
    coin_any   = |coin_e;
    coin_multi = |(coin_e & (coin_e - 4'd1));
    sum        = {1'b0, credit} + {4'b0000, coin_val};
    cnt_inc    = cnt + CW'(1);
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    credit_d = credit;
    change_d = dispenser.change;
    vsel_d   = vendSel;
    fault_d  = fault;
    disp_d   = 1'b0;
    vend_d   = 1'b0;
    rej_d    = 1'b0;
    low_d    = 1'b0;
    case (state)
      IDLE: begin
        if (cancel_e) begin
          rej_d    = coin_any;
          change_d = credit;
          credit_d = '0;
          if (credit != '0) state_d = CHANGE;
        end else if (buy_e) begin
          rej_d = coin_any;
          if (credit >= price) begin
            vend_d   = 1'b1;
            vsel_d   = sel;
            change_d = credit - price;
            credit_d = '0;
            if (credit != price) state_d = CHANGE;
          end else begin
            low_d = 1'b1;
          end
        end else if (coin_multi) begin
          rej_d = 1'b1;
        end else if (coin_any) begin
          if (sum <= 11'(MAX_CREDIT)) credit_d = sum[9:0];
          else                        rej_d    = 1'b1;
        end
      end
      CHANGE: begin
        rej_d   = coin_any;
        disp_d  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        rej_d = coin_any;
        cnt_d = cnt_inc;
        if (dispenser.dispDone) begin
          change_d = '0;
          state_d  = IDLE;
        end else if (cnt_inc == CW'(DONE_TIMEOUT)) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end
      FAULT: begin
        rej_d = coin_any;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CHANGE) || (state_d == WAIT_DONE);
  end

  // State, edge history and all outputs; reset discards any pending change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      hist             <= '0;
      cnt              <= '0;
      credit           <= '0;
      dispenser.change <= '0;
      dispenser.disp   <= 1'b0;
      vend             <= 1'b0;
      vendSel          <= '0;
      coinReject       <= 1'b0;
      lowCredit        <= 1'b0;
      busy             <= 1'b0;
      fault            <= 1'b0;
    end else begin
      state            <= state_d;
      hist             <= now;
      cnt              <= cnt_d;
      credit           <= credit_d;
      dispenser.change <= change_d;
      dispenser.disp   <= disp_d;
      vend             <= vend_d;
      vendSel          <= vsel_d;
      coinReject       <= rej_d;
      lowCredit        <= low_d;
      busy             <= busy_d;
      fault            <= fault_d;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed cycle-by-cycle vectors for vend_controller, followed by
// hand-written sequences for the done timeout and asynchronous reset.
module tb_vend_controller;

  localparam int unsigned TO = 1023;

  // Coin field order: {quarter, dime, nickel, dollar}
  localparam logic [3:0] Q = 4'b1000;
  localparam logic [3:0] D = 4'b0100;
  localparam logic [3:0] N = 4'b0010;
  localparam logic [3:0] L = 4'b0001;
  localparam logic [3:0] Z = 4'b0000;

  logic       clk, rst;
  logic       coinQuarter, coinDime, coinNickel, coinDollar, buy, cancel;
  logic [1:0] sel;
  logic [9:0] credit;
  logic       vend, coinReject, lowCredit, busy, fault;
  logic [1:0] vendSel;

  vend_controller_if dif ();

  vend_controller #(
    .PRICE0(75), .PRICE1(100), .PRICE2(125), .PRICE3(150),
    .MAX_CREDIT(1000), .DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .coinQuarter(coinQuarter), .coinDime(coinDime),
    .coinNickel(coinNickel), .coinDollar(coinDollar),
    .buy(buy), .cancel(cancel), .sel(sel),
    .dispenser(dif),
    .credit(credit), .vend(vend), .vendSel(vendSel),
    .coinReject(coinReject), .lowCredit(lowCredit),
    .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  coin;
    logic        b, c;
    logic [1:0]  s;
    logic        d;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [27:0] pk(input int cr, input int ch, input logic dp, input logic vd,
                                     input logic [1:0] vs, input logic rj, input logic lw,
                                     input logic bs, input logic ft);
    return {10'(cr), 10'(ch), dp, vd, vs, rj, lw, bs, ft};
  endfunction

  function automatic string fmt(input logic [27:0] x);
    return $sformatf("credit=%0d change=%0d disp=%0b vend=%0b vendSel=%0d coinReject=%0b lowCredit=%0b busy=%0b fault=%0b",
                     x[27:18], x[17:8], x[7], x[6], x[5:4], x[3], x[2], x[1], x[0]);
  endfunction

  function automatic void add(input logic [3:0] coin, input logic b, input logic c,
                              input logic [1:0] s, input logic d, input int cr, input int ch,
                              input logic dp, input logic vd, input logic [1:0] vs,
                              input logic rj, input logic lw, input logic bs, input logic ft);
    vec_t v;
    v.coin = coin; v.b = b; v.c = c; v.s = s; v.d = d;
    v.exp  = pk(cr, ch, dp, vd, vs, rj, lw, bs, ft);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [27:0] exp);
    logic [27:0] act;
    act = pk(int'(credit), int'(dif.change), dif.disp, vend, vendSel, coinReject, lowCredit, busy, fault);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual {%s} required {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] coin, input logic b, input logic c,
                       input logic [1:0] s, input logic d);
    {coinQuarter, coinDime, coinNickel, coinDollar} = coin;
    buy = b; cancel = c; sel = s; dif.dispDone = d;
  endtask

  task automatic cyc(input logic [3:0] coin, input logic b, input logic c,
                     input logic [1:0] s, input logic d);
    drive(coin, b, c, s, d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    //   coin  b  c  s  d  credit chg disp vend vs rej low busy flt
    // quarters x4, buy product 0 with change 25
    add(Q, 0, 0, 0, 0,   25,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,   25,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Q, 0, 0, 0, 0,   50,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,   50,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Q, 0, 0, 0, 0,   75,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,   75,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Q, 0, 0, 0, 0,  100,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,  100,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 1, 0, 0, 0,    0, 25, 0, 1, 0, 0, 0, 1, 0);
    add(Z, 0, 0, 0, 0,    0, 25, 1, 0, 0, 0, 0, 1, 0);
    add(Z, 0, 0, 0, 0,    0, 25, 0, 0, 0, 0, 0, 1, 0);
    add(Z, 0, 0, 0, 1,    0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,    0,  0, 0, 0, 0, 0, 0, 0, 0);
    // dimes x3, buy product 1 refused, then cancel; done in CHANGE ignored, coin in WAIT_DONE rejected
    add(D, 0, 0, 0, 0,   10,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,   10,  0, 0, 0, 0, 0, 0, 0, 0);
    add(D, 0, 0, 0, 0,   20,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,   20,  0, 0, 0, 0, 0, 0, 0, 0);
    add(D, 0, 0, 0, 0,   30,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,   30,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 1, 0, 1, 0,   30,  0, 0, 0, 0, 0, 1, 0, 0);
    add(Z, 0, 0, 1, 0,   30,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 1, 0, 0,    0, 30, 0, 0, 0, 0, 0, 1, 0);
    add(Z, 0, 0, 0, 1,    0, 30, 1, 0, 0, 0, 0, 1, 0);
    add(N, 0, 0, 0, 0,    0, 30, 0, 0, 0, 1, 0, 1, 0);
    add(Z, 0, 0, 0, 1,    0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,    0,  0, 0, 0, 0, 0, 0, 0, 0);
    // exact payment for product 2: vend, no change, stays idle
    add(L, 0, 0, 0, 0,  100,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,  100,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Q, 0, 0, 0, 0,  125,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,  125,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 1, 0, 2, 0,    0,  0, 0, 1, 2, 0, 0, 0, 0);
    add(Z, 0, 0, 2, 0,    0,  0, 0, 0, 2, 0, 0, 0, 0);
    // credit 75, nickel together with buy of product 0
    add(Q, 0, 0, 0, 0,   25,  0, 0, 0, 2, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,   25,  0, 0, 0, 2, 0, 0, 0, 0);
    add(Q, 0, 0, 0, 0,   50,  0, 0, 0, 2, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,   50,  0, 0, 0, 2, 0, 0, 0, 0);
    add(Q, 0, 0, 0, 0,   75,  0, 0, 0, 2, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,   75,  0, 0, 0, 2, 0, 0, 0, 0);
    add(N, 1, 0, 0, 0,    0,  0, 0, 1, 0, 1, 0, 0, 0);
    add(Z, 0, 0, 0, 0,    0,  0, 0, 0, 0, 0, 0, 0, 0);
    // two coins in one cycle are rejected
    add(N, 0, 0, 0, 0,    5,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Z, 0, 0, 0, 0,    5,  0, 0, 0, 0, 0, 0, 0, 0);
    add(Q | D, 0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(Z, 0, 0, 0, 0,    5,  0, 0, 0, 0, 0, 0, 0, 0);
    // refund the 5, done on the first WAIT_DONE cycle
    add(Z, 0, 1, 0, 0,    0,  5, 0, 0, 0, 0, 0, 1, 0);
    add(Z, 0, 0, 0, 0,    0,  5, 1, 0, 0, 0, 0, 1, 0);
    add(Z, 0, 0, 0, 1,    0,  0, 0, 0, 0, 0, 0, 0, 0);
    // dollars up to the ceiling, then overflow rejects
    for (int k = 1; k <= 10; k++) begin
      add(L, 0, 0, 0, 0, 100 * k, 0, 0, 0, 0, 0, 0, 0, 0);
      add(Z, 0, 0, 0, 0, 100 * k, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    add(L, 0, 0, 0, 0, 1000,  0, 0, 0, 0, 1, 0, 0, 0);
    add(Z, 0, 0, 0, 0, 1000,  0, 0, 0, 0, 0, 0, 0, 0);
    add(N, 0, 0, 0, 0, 1000,  0, 0, 0, 0, 1, 0, 0, 0);
    add(Z, 0, 0, 0, 0, 1000,  0, 0, 0, 0, 0, 0, 0, 0);

    drive(Z, 0, 0, 0, 0);
    dif.dispBusy = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].coin, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // buy product 3 from 1000, then withhold done until the timeout
    cyc(Z, 1, 0, 3, 0);
    check("buy3_vend", pk(0, 850, 0, 1, 3, 0, 0, 1, 0));
    cyc(Z, 0, 0, 3, 0);
    check("buy3_disp", pk(0, 850, 1, 0, 3, 0, 0, 1, 0));
    n = 0;
    while (fault !== 1'b1 && n < int'(TO) + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_int("timeout_cycles", n, int'(TO));
    check("fault_state", pk(0, 850, 0, 0, 3, 0, 0, 0, 1));
    cyc(Q, 0, 0, 0, 0);
    check("fault_coin", pk(0, 850, 0, 0, 3, 1, 0, 0, 1));
    cyc(Z, 1, 0, 0, 0);
    check("fault_buy", pk(0, 850, 0, 0, 3, 0, 0, 0, 1));
    cyc(Z, 0, 0, 0, 0);

    // reset out of FAULT, then reset asynchronously in the middle of WAIT_DONE
    rst = 1'b0;
    #1;
    check("reset_fault", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    cyc(L, 0, 0, 0, 0);
    cyc(Z, 0, 0, 0, 0);
    check("rearm_credit", pk(100, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(Z, 1, 0, 0, 0);
    check("rearm_vend", pk(0, 25, 0, 1, 0, 0, 0, 1, 0));
    cyc(Z, 0, 0, 0, 0);
    cyc(Z, 0, 0, 0, 0);
    check("rearm_wait", pk(0, 25, 0, 0, 0, 0, 0, 1, 0));
    #2;
    rst = 1'b0;
    #1;
    check("reset_async", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    rst = 1'b1;
    cyc(Q, 0, 0, 0, 0);
    cyc(Z, 0, 0, 0, 0);
    check("after_reset_coin", pk(25, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
